// File: rtl/nasti_sram_slave.sv
// NASTI (AXI4) responder over an internal single-port SRAM built from byte lanes.
// Serves one INCR burst at a time (up to 256 beats); AR and AW are arbitrated round-robin.
module nasti_sram_slave #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned MEM_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  // AW
  input  logic [ID_WIDTH-1:0]     aw_id,
  input  logic [ADDR_WIDTH-1:0]   aw_addr,
  input  logic [7:0]              aw_len,
  input  logic [2:0]              aw_size,
  input  logic [1:0]              aw_burst,
  input  logic [USER_WIDTH-1:0]   aw_user,
  input  logic                    aw_valid,
  output logic                    aw_ready,
  // W
  input  logic [DATA_WIDTH-1:0]   w_data,
  input  logic [DATA_WIDTH/8-1:0] w_strb,
  input  logic                    w_last,
  input  logic [USER_WIDTH-1:0]   w_user,
  input  logic                    w_valid,
  output logic                    w_ready,
  // B
  output logic [ID_WIDTH-1:0]     b_id,
  output logic [1:0]              b_resp,
  output logic [USER_WIDTH-1:0]   b_user,
  output logic                    b_valid,
  input  logic                    b_ready,
  // AR
  input  logic [ID_WIDTH-1:0]     ar_id,
  input  logic [ADDR_WIDTH-1:0]   ar_addr,
  input  logic [7:0]              ar_len,
  input  logic [2:0]              ar_size,
  input  logic [1:0]              ar_burst,
  input  logic [USER_WIDTH-1:0]   ar_user,
  input  logic                    ar_valid,
  output logic                    ar_ready,
  // R
  output logic [ID_WIDTH-1:0]     r_id,
  output logic [DATA_WIDTH-1:0]   r_data,
  output logic [1:0]              r_resp,
  output logic                    r_last,
  output logic [USER_WIDTH-1:0]   r_user,
  output logic                    r_valid,
  input  logic                    r_ready,
  output logic                    busy
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned SHIFT = $clog2(StrbW);
  localparam int unsigned IdxW  = $clog2(MEM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] MemWords = ADDR_WIDTH'(MEM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] MemBytes = ADDR_WIDTH'(MEM_WORDS * StrbW);
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [1:0] {StIdle, StRd, StWr, StWresp} state_e;

  state_e                state_q, state_d;
  logic                  rr_pri_q, rr_pri_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [7:0]            len_q, len_d;
  logic                  err_q, err_d;    // whole-burst error (bad burst/size/start address)
  logic                  berr_q, berr_d;  // sticky write-response error
  logic [8:0]            beat_q, beat_d;  // RD: next beat to fetch; WR: current beat
  logic [ADDR_WIDTH-1:0] widx_q, widx_d;  // word index matching beat_q

  // Read pipeline: SRAM output stage plus a 2-entry buffer behind it.
  logic                  rd_vld_q, rd_err_q, rd_last_q;
  logic [DATA_WIDTH-1:0] rdata;
  logic [DATA_WIDTH-1:0] buf0_q, buf1_q;
  logic [1:0]            buf_err_q, buf_last_q;
  logic                  wptr_q, rptr_q;
  logic [1:0]            cnt_q;

  logic                  iss, iss_err, iss_last, mem_we, pop, push;
  logic [IdxW-1:0]       iss_idx;
  logic [2:0]            occ;
  logic [ADDR_WIDTH-1:0] ar_off, aw_off, ar_widx, aw_widx;
  logic                  ar_bad, aw_bad;

  logic unused_user;
  assign unused_user = ^{ar_user, aw_user, w_user};

  assign ar_off  = ar_addr - BASE_ADDR;
  assign aw_off  = aw_addr - BASE_ADDR;
  assign ar_widx = ar_off >> SHIFT;
  assign aw_widx = aw_off >> SHIFT;
  // Addresses below BASE_ADDR wrap to huge offsets, so one compare covers both bounds.
  assign ar_bad  = (ar_burst != 2'b01) || (ar_size != 3'(SHIFT)) || (ar_off >= MemBytes);
  assign aw_bad  = (aw_burst != 2'b01) || (aw_size != 3'(SHIFT)) || (aw_off >= MemBytes);

  assign r_valid = rd_vld_q || (cnt_q != 2'd0);
  assign pop     = r_valid && r_ready;
  // The SRAM stage bypasses the buffer when empty; otherwise it is queued.
  assign push    = rd_vld_q && !((cnt_q == 2'd0) && pop);
  assign occ     = {1'b0, cnt_q} + {2'b00, rd_vld_q} - {2'b00, pop};

  // Next-state, handshakes and SRAM command decode.
  always_comb begin
    state_d  = state_q;
    rr_pri_d = rr_pri_q;
    id_d     = id_q;
    len_d    = len_q;
    err_d    = err_q;
    berr_d   = berr_q;
    beat_d   = beat_q;
    widx_d   = widx_q;
    ar_ready = 1'b0;
    aw_ready = 1'b0;
    w_ready  = 1'b0;
    b_valid  = 1'b0;
    mem_we   = 1'b0;
    iss      = 1'b0;
    iss_idx  = widx_q[IdxW-1:0];
    iss_err  = err_q || (widx_q >= MemWords);
    iss_last = (beat_q == {1'b0, len_q});
    unique case (state_q)
      StIdle: begin
        ar_ready = ar_valid && (!aw_valid || !rr_pri_q);
        aw_ready = aw_valid && (!ar_valid || rr_pri_q);
        if (ar_ready) begin
          // Beat 0 is fetched in the handshake cycle for 1-cycle latency.
          iss      = 1'b1;
          iss_idx  = ar_widx[IdxW-1:0];
          iss_err  = ar_bad || (ar_widx >= MemWords);
          iss_last = (ar_len == 8'd0);
          id_d     = ar_id;
          len_d    = ar_len;
          err_d    = ar_bad;
          rr_pri_d = ~rr_pri_q;
          beat_d   = 9'd1;
          widx_d   = ar_widx + ADDR_WIDTH'(1);
          state_d  = StRd;
        end else if (aw_ready) begin
          id_d     = aw_id;
          len_d    = aw_len;
          err_d    = aw_bad;
          berr_d   = 1'b0;
          rr_pri_d = ~rr_pri_q;
          beat_d   = 9'd0;
          widx_d   = aw_widx;
          state_d  = StWr;
        end
      end
      StRd: begin
        if ((beat_q <= {1'b0, len_q}) && (occ <= 3'd1)) begin
          iss    = 1'b1;
          beat_d = beat_q + 9'd1;
          widx_d = widx_q + ADDR_WIDTH'(1);
        end
        if (pop && r_last) state_d = StIdle;
      end
      StWr: begin
        w_ready = 1'b1;
        if (w_valid) begin
          if (err_q || (widx_q >= MemWords)) berr_d = 1'b1;
          else                               mem_we = 1'b1;
          if (w_last != iss_last) berr_d = 1'b1;
          beat_d = beat_q + 9'd1;
          widx_d = widx_q + ADDR_WIDTH'(1);
          if (iss_last) state_d = StWresp;
        end
      end
      StWresp: begin
        b_valid = 1'b1;
        if (b_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= StIdle;
      rr_pri_q <= 1'b0;
      id_q     <= '0;
      len_q    <= '0;
      err_q    <= 1'b0;
      berr_q   <= 1'b0;
      beat_q   <= '0;
      widx_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_pri_q <= rr_pri_d;
      id_q     <= id_d;
      len_q    <= len_d;
      err_q    <= err_d;
      berr_q   <= berr_d;
      beat_q   <= beat_d;
      widx_q   <= widx_d;
    end
  end

  // SRAM byte lanes: byte-enabled write, registered read; contents are never reset.
  for (genvar g = 0; g < StrbW; g++) begin : g_lane
    logic [7:0] lane_mem [MEM_WORDS];
    logic [7:0] lane_rd_q;
    always_ff @(posedge aclk) begin
      if (mem_we && w_strb[g]) lane_mem[widx_q[IdxW-1:0]] <= w_data[8*g +: 8];
      if (iss) lane_rd_q <= lane_mem[iss_idx];
    end
    assign rdata[8*g +: 8] = lane_rd_q;
  end

  // Read pipeline tags and output buffer.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_vld_q   <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_last_q  <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      buf_err_q  <= '0;
      buf_last_q <= '0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      rd_vld_q  <= iss;
      rd_err_q  <= iss_err;
      rd_last_q <= iss_last;
      if (push) begin
        if (wptr_q) buf1_q <= rd_err_q ? '0 : rdata;
        else        buf0_q <= rd_err_q ? '0 : rdata;
        buf_err_q[wptr_q]  <= rd_err_q;
        buf_last_q[wptr_q] <= rd_last_q;
        wptr_q <= ~wptr_q;
      end
      if (pop && (cnt_q != 2'd0)) rptr_q <= ~rptr_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop && (cnt_q != 2'd0)};
    end
  end

  // R/B payload: buffer head when occupied, else the SRAM stage (zero when idle or errored).
  always_comb begin
    r_data = '0;
    r_resp = RespOkay;
    r_last = 1'b0;
    if (cnt_q != 2'd0) begin
      r_data = rptr_q ? buf1_q : buf0_q;
      r_resp = buf_err_q[rptr_q] ? RespSlvErr : RespOkay;
      r_last = buf_last_q[rptr_q];
    end else if (rd_vld_q) begin
      r_data = rd_err_q ? '0 : rdata;
      r_resp = rd_err_q ? RespSlvErr : RespOkay;
      r_last = rd_last_q;
    end
  end

  assign r_id   = id_q;
  assign r_user = '0;
  assign b_id   = id_q;
  assign b_resp = berr_q ? RespSlvErr : RespOkay;
  assign b_user = '0;
  assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_nasti_sram_slave.sv
// Bench for nasti_sram_slave: a table of directed write/read transactions with hand-computed
// responses, plus hand-written sequences for arbitration from reset and reset mid-burst.
module tb_nasti_sram_slave;

  localparam logic [63:0] INC = 64'h0000_0001_0000_0001;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [3:0]  aw_id, ar_id, b_id, r_id;
  logic [63:0] aw_addr, ar_addr, w_data, r_data;
  logic [7:0]  aw_len, ar_len, w_strb;
  logic [2:0]  aw_size, ar_size;
  logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
  logic [0:0]  aw_user, ar_user, w_user, b_user, r_user;
  logic        aw_valid, aw_ready, w_last, w_valid, w_ready, b_valid, b_ready;
  logic        ar_valid, ar_ready, r_last, r_valid, r_ready, busy;

  always #5 aclk = ~aclk;

  nasti_sram_slave #(
    .ADDR_WIDTH(64), .DATA_WIDTH(64), .ID_WIDTH(4), .USER_WIDTH(1),
    .MEM_WORDS(1024), .BASE_ADDR(64'h0)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size),
    .aw_burst(aw_burst), .aw_user(aw_user), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_user(w_user),
    .w_valid(w_valid), .w_ready(w_ready),
    .b_id(b_id), .b_resp(b_resp), .b_user(b_user), .b_valid(b_valid), .b_ready(b_ready),
    .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size),
    .ar_burst(ar_burst), .ar_user(ar_user), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_user(r_user),
    .r_valid(r_valid), .r_ready(r_ready), .busy(busy)
  );

  typedef struct {
    bit          wr;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [2:0]  size;
    logic [7:0]  strb;
    logic [63:0] dbase;       // beat i data = dbase + i*INC
    int          early_last;  // write: beat carrying w_last (-1 = proper last)
    int          err_from;    // read: first SLVERR beat
    logic [1:0]  exp_b;
    bit          rnd;         // read: random r_ready
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nfail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic void add(input bit wr, input logic [63:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, input logic [2:0] size,
                              input logic [7:0] strb, input logic [63:0] dbase,
                              input int early_last, input int err_from,
                              input logic [1:0] exp_b, input bit rnd);
    vec_t v;
    v.wr = wr; v.addr = addr; v.len = len; v.burst = burst; v.size = size; v.strb = strb;
    v.dbase = dbase; v.early_last = early_last; v.err_from = err_from; v.exp_b = exp_b;
    v.rnd = rnd;
    tbl.push_back(v);
  endfunction

  // Address handshake; entered and left 1 time unit after a rising edge.
  task automatic addr_hs(input vec_t v, input logic [3:0] id);
    int n = 0;
    if (v.wr) begin
      aw_valid = 1'b1; aw_addr = v.addr; aw_len = v.len; aw_size = v.size;
      aw_burst = v.burst; aw_id = id;
    end else begin
      ar_valid = 1'b1; ar_addr = v.addr; ar_len = v.len; ar_size = v.size;
      ar_burst = v.burst; ar_id = id;
    end
    @(negedge aclk);
    while (!(v.wr ? aw_ready : ar_ready) && n < 100) begin
      @(negedge aclk);
      n++;
    end
    if (!(v.wr ? aw_ready : ar_ready)) check("addr_timeout", 64'd0, 64'd1);
    else if (!v.wr) check("r_valid_in_ar_cycle", 64'(r_valid), 64'd0);
    @(posedge aclk);
    #1;
    aw_valid = 1'b0;
    ar_valid = 1'b0;
  endtask

  task automatic do_write(input vec_t v, input logic [3:0] id);
    int n;
    addr_hs(v, id);
    for (int i = 0; i <= int'(v.len); i++) begin
      n = 0;
      w_valid = 1'b1;
      w_data  = v.dbase + 64'(i) * INC;
      w_strb  = v.strb;
      w_last  = (v.early_last >= 0) ? (i == v.early_last) : (i == int'(v.len));
      @(negedge aclk);
      while (!w_ready && n < 100) begin
        @(negedge aclk);
        n++;
      end
      if (!w_ready) check("w_timeout", 64'd0, 64'd1);
      @(posedge aclk);
      #1;
    end
    w_valid = 1'b0;
    w_last  = 1'b0;
    b_ready = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!b_valid && n < 100) begin
      @(negedge aclk);
      n++;
    end
    check("b_resp", 64'(b_resp), 64'(v.exp_b));
    check("b_id", 64'(b_id), 64'(id));
    @(posedge aclk);
    #1;
    b_ready = 1'b0;
    check("busy_after_b", 64'(busy), 64'd0);
  endtask

  task automatic do_read(input vec_t v, input logic [3:0] id);
    int          beat = 0;
    int          cyc = 0;
    bit          stalled = 1'b0;
    bit          first = 1'b1;
    logic [63:0] pdata, edata;
    logic [2:0]  pctl;
    logic [1:0]  eresp;
    addr_hs(v, id);
    while (beat <= int'(v.len) && cyc < 3000) begin
      r_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge aclk);
      if (first) check("r_latency", 64'(r_valid), 64'd1);
      first = 1'b0;
      if (stalled) begin
        check("r_stable_data", r_data, pdata);
        check("r_stable_ctl", 64'({r_last, r_resp}), 64'(pctl));
      end
      stalled = 1'b0;
      if (r_valid) begin
        if (r_ready) begin
          edata = (beat >= v.err_from) ? 64'd0 : v.dbase + 64'(beat) * INC;
          eresp = (beat >= v.err_from) ? 2'b10 : 2'b00;
          check("r_data", r_data, edata);
          check("r_resp", 64'(r_resp), 64'(eresp));
          check("r_last", 64'(r_last), 64'(beat == int'(v.len)));
          if (beat == 0) check("r_id", 64'(r_id), 64'(id));
          beat++;
        end else begin
          stalled = 1'b1;
          pdata = r_data;
          pctl = {r_last, r_resp};
        end
      end
      @(posedge aclk);
      #1;
      cyc++;
    end
    r_ready = 1'b0;
    if (beat <= int'(v.len)) check("r_timeout", 64'(beat), 64'(int'(v.len) + 1));
    check("busy_after_r", 64'(busy), 64'd0);
  endtask

  initial begin
    vec_t v;
    int   n;
    aw_id = '0; aw_addr = '0; aw_len = '0; aw_size = 3'd3; aw_burst = 2'b01; aw_user = '0;
    ar_id = '0; ar_addr = '0; ar_len = '0; ar_size = 3'd3; ar_burst = 2'b01; ar_user = '0;
    aw_valid = 0; ar_valid = 0; w_valid = 0; w_last = 0; w_data = '0; w_strb = '0;
    w_user = '0; b_ready = 0; r_ready = 0;

    //  wr  addr         len   burst  size  strb   data base                 early err  b      rnd
    add(1, 64'h40,   8'd0,   2'b01, 3'd3, 8'hFF, 64'hDEADBEEF_CAFEF00D, -1, 999, 2'b00, 0);
    add(0, 64'h40,   8'd0,   2'b01, 3'd3, 8'hFF, 64'hDEADBEEF_CAFEF00D, -1, 999, 2'b00, 0);
    add(1, 64'h0,    8'd0,   2'b01, 3'd3, 8'hFF, 64'h0,                 -1, 999, 2'b00, 0);
    add(1, 64'h0,    8'd0,   2'b01, 3'd3, 8'h0F, 64'hFFFFFFFF_FFFFFFFF, -1, 999, 2'b00, 0);
    add(0, 64'h0,    8'd0,   2'b01, 3'd3, 8'hFF, 64'h00000000_FFFFFFFF, -1, 999, 2'b00, 0);
    add(1, 64'h1FF8, 8'd0,   2'b01, 3'd3, 8'hFF, 64'h11112222_33334444, -1, 999, 2'b00, 0);
    add(0, 64'h1FF8, 8'd1,   2'b01, 3'd3, 8'hFF, 64'h11112222_33334444, -1, 1,   2'b00, 0);
    add(1, 64'h100,  8'd0,   2'b01, 3'd3, 8'hFF, 64'h77777777_77777777, -1, 999, 2'b00, 0);
    add(1, 64'h100,  8'd0,   2'b00, 3'd3, 8'hFF, 64'h55555555_55555555, -1, 999, 2'b10, 0);
    add(0, 64'h100,  8'd0,   2'b01, 3'd3, 8'hFF, 64'h77777777_77777777, -1, 999, 2'b00, 0);
    add(1, 64'h200,  8'd3,   2'b01, 3'd3, 8'hFF, 64'h90000000_00000000, 2,  999, 2'b10, 0);
    add(0, 64'h200,  8'd3,   2'b01, 3'd3, 8'hFF, 64'h90000000_00000000, -1, 999, 2'b00, 0);
    add(1, 64'h2000, 8'd0,   2'b01, 3'd3, 8'hFF, 64'h12345678_12345678, -1, 999, 2'b10, 0);
    add(0, 64'h40,   8'd1,   2'b01, 3'd2, 8'hFF, 64'h0,                 -1, 0,   2'b00, 0);
    add(1, 64'h400,  8'd255, 2'b01, 3'd3, 8'hFF, 64'hC0DE0000_00000000, -1, 999, 2'b00, 0);
    add(0, 64'h400,  8'd255, 2'b01, 3'd3, 8'hFF, 64'hC0DE0000_00000000, -1, 999, 2'b00, 1);

    repeat (3) @(posedge aclk);
    #1;
    // Reset values.
    check("rst_r_valid", 64'(r_valid), 64'd0);
    check("rst_b_valid", 64'(b_valid), 64'd0);
    check("rst_w_ready", 64'(w_ready), 64'd0);
    check("rst_ar_ready", 64'(ar_ready), 64'd0);
    check("rst_r_data", r_data, 64'd0);
    check("rst_resp", 64'({r_resp, b_resp}), 64'd0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);

    // Tie from reset: read first, then the pending write, then read wins the next tie.
    ar_valid = 1; ar_addr = 64'h80; ar_len = 0; ar_id = 4'd1;
    aw_valid = 1; aw_addr = 64'h88; aw_len = 0; aw_id = 4'd2;
    @(negedge aclk);
    check("tie1_ar_ready", 64'(ar_ready), 64'd1);
    check("tie1_aw_ready", 64'(aw_ready), 64'd0);
    @(posedge aclk); #1; ar_valid = 0; r_ready = 1;
    @(negedge aclk);
    check("tie1_r_valid", 64'(r_valid), 64'd1);
    check("tie1_aw_blocked", 64'(aw_ready), 64'd0);
    @(posedge aclk); #1; r_ready = 0;
    @(negedge aclk);
    check("tie1_aw_next", 64'(aw_ready), 64'd1);
    @(posedge aclk); #1; aw_valid = 0;
    w_valid = 1; w_last = 1; w_strb = 8'hFF; w_data = 64'h0;
    @(negedge aclk);
    check("tie1_w_ready", 64'(w_ready), 64'd1);
    @(posedge aclk); #1; w_valid = 0; w_last = 0; b_ready = 1;
    @(negedge aclk);
    check("tie1_b_valid", 64'(b_valid), 64'd1);
    @(posedge aclk); #1; b_ready = 0;
    ar_valid = 1; aw_valid = 1;
    @(negedge aclk);
    check("tie2_ar_ready", 64'(ar_ready), 64'd1);
    check("tie2_aw_ready", 64'(aw_ready), 64'd0);
    @(posedge aclk); #1; ar_valid = 0; r_ready = 1;
    @(posedge aclk); #1; r_ready = 0;
    n = 0;
    @(negedge aclk);
    while (!aw_ready && n < 20) begin @(negedge aclk); n++; end
    check("tie2_aw_after", 64'(aw_ready), 64'd1);
    @(posedge aclk); #1; aw_valid = 0; w_valid = 1; w_last = 1;
    @(posedge aclk); #1; w_valid = 0; w_last = 0; b_ready = 1;
    @(posedge aclk); #1; b_ready = 0;
    check("tie2_idle", 64'(busy), 64'd0);

    // Directed table.
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].wr) do_write(tbl[i], 4'(i));
      else           do_read(tbl[i], 4'(i));
    end

    // Reset during beat 5 of a 16-beat read.
    v = tbl[15];
    v.len = 8'd15;
    addr_hs(v, 4'd7);
    r_ready = 1;
    n = 0;
    for (int b = 0; b < 5 && n < 100; ) begin
      @(negedge aclk);
      if (r_valid) b++;
      @(posedge aclk); #1;
      n++;
    end
    @(negedge aclk);
    check("mid_beat5_valid", 64'(r_valid), 64'd1);
    check("mid_beat5_data", r_data, 64'hC0DE0000_00000000 + 64'd5 * INC);
    #1 aresetn = 1'b0;
    #1;
    check("mid_rst_r_valid", 64'(r_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    r_ready = 0;
    @(posedge aclk); #1; aresetn = 1'b1;
    @(posedge aclk); #1;
    r_ready = 1;
    @(negedge aclk);
    check("post_rst_no_beat", 64'(r_valid), 64'd0);
    @(posedge aclk); #1; r_ready = 0;
    do_read(tbl[1], 4'd9);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  // Global watchdog so a stuck handshake still ends the run.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
